reshaper_mem_rsp: RTL and testbench
===================================

Name: reshaper_mem_rsp

Overview:
- Fixed-latency memory responder: the target end of the reshaper's read/write memory interface.
- Accepts read requests (raddr/raddr_vld) and returns rdata/rdata_vld exactly MEM_DELAY cycles later.
- Accepts single-cycle writes (waddr/wdata/wdata_vld).
- Serves as the on-chip scratchpad model and synthesizable buffer behind the reshaper in block-level and subsystem benches.

Parameters:
- AW, 16, address width.
- DW, 512, data word width.
- DEPTH, 1024, number of DW-bit words implemented; must be ≤ 2**AW.
- MEM_DELAY, 8, read latency in cycles from raddr_vld to rdata_vld; legal range 1..32.

Ports:
- clk  input  1  clock; all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- init_pulse  input  1  one-cycle pulse; clears the error flag and statistics.
- raddr  input  AW  read word address.
- raddr_vld  input  1  read request strobe; one request per cycle, no backpressure.
- rdata  output  DW  read data.
- rdata_vld  output  1  read data valid.
- waddr  input  AW  write word address.
- wdata  input  DW  write data.
- wdata_vld  input  1  write strobe.
- addr_err  output  1  sticky flag: any access with address ≥ DEPTH.
- rd_cnt  output  AW  accepted read count (optional feature).
- wr_cnt  output  AW  accepted write count (optional feature).

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: rdata=0, rdata_vld=0, addr_err=0, rd_cnt=0, wr_cnt=0.
- On reset, all pipeline valid bits clear. Memory array contents are NOT cleared.
- Read:
  - Array is sampled in the request cycle T (cycle where raddr_vld=1).
  - Data is carried through a MEM_DELAY-deep valid/data shift pipeline.
  - rdata_vld=1 with the data in cycle T+MEM_DELAY. MEM_DELAY=1 means registered output in the next cycle.
  - Back-to-back reads every cycle give back-to-back rdata_vld in the same order. No bubbles, no reordering.
- Write: array updated at end of cycle where wdata_vld=1 and waddr<DEPTH. Single write per cycle.
- Read/write same cycle, same address: write-first bypass; the read returns the new wdata.
- Write to an address after a read was issued, while that read is in flight: the read returns the value sampled at issue. A later write does not alter in-flight data.
- Out-of-range read (raddr≥DEPTH): rdata_vld still asserted at T+MEM_DELAY with rdata=0; addr_err set the next cycle.
- Out-of-range write: dropped, memory unchanged; addr_err set the next cycle.
- addr_err is sticky until reset or init_pulse. If init_pulse and a new error occur in the same cycle, the error wins and addr_err=1.
- init_pulse does not flush in-flight reads.
- rdata holds its last value when rdata_vld=0.
- Address arithmetic: compare raddr/waddr as unsigned AW-bit values. Index the array with the low clog2(DEPTH) bits only after the range check passes.
- Reset mid-operation: in-flight reads are discarded and no rdata_vld is produced for them. Pending writes in the reset cycle are ignored.

Optional Feature:
- Macro: RESHAPER_MEM_RSP_STATS_EN.
- Defined:
  - rd_cnt increments per accepted raddr_vld; wr_cnt increments per wdata_vld with an in-range address.
  - Both counters wrap modulo 2**AW.
  - Both clear on reset or init_pulse. A same-cycle increment after the clear is lost and the counter reads 0.
- Undefined: rd_cnt and wr_cnt are tied to 0 and no counter flops are inferred.

Decomposition:
- Package reshaper_mem_pkg holds:
  - typedef rsp_stage_t {logic vld; logic [DW-1:0] data;}, parameterized through a package-level DW localparam of 512, with a static assert that the module DW matches.
  - localparam MAX_MEM_DELAY=32.
- One sub-module: reshaper_mem_dly_pipe, a parameterized N-stage valid/data shift register with synchronous clear of the valid bits.
- The top holds the array, bypass, range check, error flag and counters.

Test Plan:
1. Reset, write 0xA5..A5 to addr 3 at cycle 5, read addr 3 at cycle 6 -> rdata_vld=1 with 0xA5..A5 at cycle 14 (MEM_DELAY=8).
2. Reads of addr 0..15 on 16 consecutive cycles after preload data=addr -> 16 consecutive rdata_vld cycles returning 0..15 in order.
3. Same cycle: write 0x77 and read addr 10 -> rdata=0x77 after 8 cycles. Read addr 11, then write 0x55 to addr 11 one cycle later -> returns the old value.
4. Read addr 1024 (DEPTH=1024) -> rdata_vld with rdata=0 at T+8, addr_err=1 at T+1. Pulse init_pulse -> addr_err=0 next cycle.
5. Issue 4 reads, assert reset 3 cycles later -> no rdata_vld for 10 cycles. Memory still returns prior contents on re-read.
6. With RESHAPER_MEM_RSP_STATS_EN: 5 reads + 3 in-range writes + 1 out-of-range write -> rd_cnt=5, wr_cnt=3. init_pulse -> both 0.

Source files
------------

// File: rtl/reshaper_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reshaper_mem_pkg
// Description : Shared types and limits for the reshaper memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package reshaper_mem_pkg;

    localparam int PKG_DW        = 512;
    localparam int MAX_MEM_DELAY = 32;

    typedef struct packed {
        logic              vld;
        logic [PKG_DW-1:0] data;
    } rsp_stage_t;

endpackage : reshaper_mem_pkg
`default_nettype wire

// File: rtl/reshaper_mem_rsp_if.sv
`default_nettype none
// ============================================================================
// Module      : reshaper_mem_rsp_if
// Description : Read/write memory port between the reshaper and its memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface reshaper_mem_rsp_if #(
    parameter int AW = 16,
    parameter int DW = 512
);
    logic [AW-1:0] raddr;
    logic          raddr_vld;
    logic [DW-1:0] rdata;
    logic          rdata_vld;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          wdata_vld;

    modport master (
        output raddr, raddr_vld, waddr, wdata, wdata_vld,
        input  rdata, rdata_vld
    );

    modport slave (
        input  raddr, raddr_vld, waddr, wdata, wdata_vld,
        output rdata, rdata_vld
    );
endinterface : reshaper_mem_rsp_if
`default_nettype wire

// File: rtl/reshaper_mem_dly_pipe.sv
`default_nettype none
// ============================================================================
// Module      : reshaper_mem_dly_pipe
// Description : N-stage valid/data shift register; data advances only with
//               its valid bit so the last stage holds its previous word.
// Revision    : 1.0 - initial release
// ============================================================================
module reshaper_mem_dly_pipe
    import reshaper_mem_pkg::*;
#(
    parameter int N = 8
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire rsp_stage_t i_stage,
    output rsp_stage_t      o_stage
);

    rsp_stage_t r_stage [N];

    generate
        if (N < 1 || N > MAX_MEM_DELAY) begin : g_n_check
            $error("reshaper_mem_dly_pipe: N out of range");
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0].vld <= i_stage.vld;
            if (i_stage.vld) begin
                r_stage[0].data <= i_stage.data;
            end
            for (int i = 1; i < N; i++) begin
                r_stage[i].vld <= r_stage[i-1].vld;
                if (r_stage[i-1].vld) begin
                    r_stage[i].data <= r_stage[i-1].data;
                end
            end
        end
    end

    assign o_stage = r_stage[N-1];

endmodule : reshaper_mem_dly_pipe
`default_nettype wire

// File: rtl/reshaper_mem_rsp.sv
`default_nettype none
// ============================================================================
// Module      : reshaper_mem_rsp
// Description : Fixed-latency memory responder with write-first bypass,
//               sticky range error and optional access statistics
//               (enabled by RESHAPER_MEM_RSP_STATS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module reshaper_mem_rsp
    import reshaper_mem_pkg::*;
#(
    parameter int AW        = 16,
    parameter int DW        = 512,
    parameter int DEPTH     = 1024,
    parameter int MEM_DELAY = 8
) (
    input  wire logic           clk,
    input  wire logic           reset,
    input  wire logic           init_pulse,
    reshaper_mem_rsp_if.slave   mem,
    output logic                addr_err,
    output logic [AW-1:0]       rd_cnt,
    output logic [AW-1:0]       wr_cnt
);

    localparam int          c_IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    generate
        if (DW != PKG_DW) begin : g_dw_check
            $error("reshaper_mem_rsp: DW must match reshaper_mem_pkg::PKG_DW");
        end
        if (MEM_DELAY < 1 || MEM_DELAY > MAX_MEM_DELAY) begin : g_dly_check
            $error("reshaper_mem_rsp: MEM_DELAY out of range");
        end
        if (DEPTH < 1 || DEPTH > (2 ** AW)) begin : g_depth_check
            $error("reshaper_mem_rsp: DEPTH out of range");
        end
    endgenerate

    logic [DW-1:0]   r_mem [DEPTH];
    logic            r_addr_err;
    logic            w_rd_in_range;
    logic            w_wr_in_range;
    logic            w_wr_en;
    logic            w_bypass;
    logic            w_new_err;
    logic [c_IW-1:0] w_rd_idx;
    logic [c_IW-1:0] w_wr_idx;
    rsp_stage_t      w_rd_stage;
    rsp_stage_t      w_rsp_stage;

    // Range check on the full unsigned address before any truncation.
    assign w_rd_in_range = ({1'b0, mem.raddr} < c_DEPTH);
    assign w_wr_in_range = ({1'b0, mem.waddr} < c_DEPTH);
    assign w_rd_idx      = mem.raddr[c_IW-1:0];
    assign w_wr_idx      = mem.waddr[c_IW-1:0];
    assign w_wr_en       = mem.wdata_vld && w_wr_in_range && !reset;
    assign w_bypass      = mem.wdata_vld && w_wr_in_range && (mem.waddr == mem.raddr);
    assign w_new_err     = (mem.raddr_vld && !w_rd_in_range) ||
                           (mem.wdata_vld && !w_wr_in_range);

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= mem.wdata;
        end
    end

    // Sample in the request cycle; later writes cannot reach in-flight data.
    always_comb begin
        w_rd_stage      = '0;
        w_rd_stage.vld  = mem.raddr_vld;
        if (w_rd_in_range) begin
            w_rd_stage.data = w_bypass ? mem.wdata : r_mem[w_rd_idx];
        end
    end

    reshaper_mem_dly_pipe #(
        .N (MEM_DELAY)
    ) u_dly_pipe (
        .clk     (clk),
        .rst     (reset),
        .i_stage (w_rd_stage),
        .o_stage (w_rsp_stage)
    );

    assign mem.rdata     = w_rsp_stage.data;
    assign mem.rdata_vld = w_rsp_stage.vld;

    // A fresh error outranks a same-cycle init_pulse clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_err <= 1'b0;
        end else if (w_new_err) begin
            r_addr_err <= 1'b1;
        end else if (init_pulse) begin
            r_addr_err <= 1'b0;
        end
    end

    assign addr_err = r_addr_err;

`ifdef RESHAPER_MEM_RSP_STATS_EN
    logic [AW-1:0] r_rd_cnt;
    logic [AW-1:0] r_wr_cnt;

    always_ff @(posedge clk) begin
        if (reset || init_pulse) begin
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            if (mem.raddr_vld) begin
                r_rd_cnt <= r_rd_cnt + AW'(1);
            end
            if (mem.wdata_vld && w_wr_in_range) begin
                r_wr_cnt <= r_wr_cnt + AW'(1);
            end
        end
    end

    assign rd_cnt = r_rd_cnt;
    assign wr_cnt = r_wr_cnt;
`else
    assign rd_cnt = '0;
    assign wr_cnt = '0;
`endif

endmodule : reshaper_mem_rsp
`default_nettype wire

// File: tb/tb_reshaper_mem_rsp.sv
`default_nettype none
// ============================================================================
// Module      : tb_reshaper_mem_rsp
// Description : Self-checking bench for reshaper_mem_rsp against a queue-based
//               reference model of the memory and its response schedule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reshaper_mem_rsp;

    localparam int AW        = 16;
    localparam int DW        = 512;
    localparam int DEPTH     = 1024;
    localparam int MEM_DELAY = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          init_pulse;
    logic          addr_err;
    logic [AW-1:0] rd_cnt;
    logic [AW-1:0] wr_cnt;

    always #5 clk = ~clk;

    reshaper_mem_rsp_if #(.AW(AW), .DW(DW)) mem_if ();

    reshaper_mem_rsp #(
        .AW        (AW),
        .DW        (DW),
        .DEPTH     (DEPTH),
        .MEM_DELAY (MEM_DELAY)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .init_pulse (init_pulse),
        .mem        (mem_if),
        .addr_err   (addr_err),
        .rd_cnt     (rd_cnt),
        .wr_cnt     (wr_cnt)
    );

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          m_q [$];
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_rdata;
    logic          m_vld;
    logic          m_err;
    logic [AW-1:0] m_rd_cnt;
    logic [AW-1:0] m_wr_cnt;
    int            tick;
    int            n_checks;
    int            n_errs;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s @tick %0d: got %0h expected %0h", tag, tick, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) begin
            w[i*32 +: 32] = $urandom;
        end
        return w;
    endfunction

    // Spec-level model: each request schedules its response MEM_DELAY cycles on.
    task automatic model_tick();
        int            ra;
        int            wa;
        logic          rd_ok;
        logic          wr_ok;
        logic [DW-1:0] d;
        tick++;
        ra    = int'(mem_if.raddr);
        wa    = int'(mem_if.waddr);
        rd_ok = (ra < DEPTH);
        wr_ok = (wa < DEPTH);
        if (reset) begin
            m_q.delete();
            m_rdata  = '0;
            m_vld    = 1'b0;
            m_err    = 1'b0;
            m_rd_cnt = '0;
            m_wr_cnt = '0;
        end else begin
            if (mem_if.raddr_vld) begin
                if (!rd_ok)
                    d = '0;
                else if (mem_if.wdata_vld && wr_ok && wa == ra)
                    d = mem_if.wdata;
                else
                    d = m_mem[ra];
                m_q.push_back('{due: tick + MEM_DELAY - 1, data: d});
            end
            if (mem_if.wdata_vld && wr_ok)
                m_mem[wa] = mem_if.wdata;
            if ((mem_if.raddr_vld && !rd_ok) || (mem_if.wdata_vld && !wr_ok))
                m_err = 1'b1;
            else if (init_pulse)
                m_err = 1'b0;
            if (init_pulse) begin
                m_rd_cnt = '0;
                m_wr_cnt = '0;
            end else begin
                if (mem_if.raddr_vld)
                    m_rd_cnt = m_rd_cnt + 1'b1;
                if (mem_if.wdata_vld && wr_ok)
                    m_wr_cnt = m_wr_cnt + 1'b1;
            end
            m_vld = 1'b0;
            if (m_q.size() > 0 && m_q[0].due == tick) begin
                m_vld   = 1'b1;
                m_rdata = m_q[0].data;
                void'(m_q.pop_front());
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        @(negedge clk);
        chk("rdata_vld", DW'(mem_if.rdata_vld), DW'(m_vld));
        chk("rdata", mem_if.rdata, m_rdata);
        chk("addr_err", DW'(addr_err), DW'(m_err));
`ifdef RESHAPER_MEM_RSP_STATS_EN
        chk("rd_cnt", DW'(rd_cnt), DW'(m_rd_cnt));
        chk("wr_cnt", DW'(wr_cnt), DW'(m_wr_cnt));
`else
        chk("rd_cnt", DW'(rd_cnt), '0);
        chk("wr_cnt", DW'(wr_cnt), '0);
`endif
    endtask

    task automatic cyc(input bit rv, input int ra, input bit wv, input int wa,
                       input logic [DW-1:0] wd, input bit ip = 1'b0, input bit rs = 1'b0);
        mem_if.raddr_vld = rv;
        mem_if.raddr     = AW'(ra);
        mem_if.wdata_vld = wv;
        mem_if.waddr     = AW'(wa);
        mem_if.wdata     = wd;
        init_pulse       = ip;
        reset            = rs;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, 0, '0);
    endtask

    initial begin
        n_checks = 0;
        n_errs   = 0;
        tick     = 0;
        m_rdata  = '0;
        m_vld    = 1'b0;
        m_err    = 1'b0;
        m_rd_cnt = '0;
        m_wr_cnt = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 'x;

        cyc(1'b0, 0, 1'b0, 0, '0, 1'b0, 1'b1);
        cyc(1'b0, 0, 1'b0, 0, '0, 1'b0, 1'b1);

        // Preload: low words hold their own address, the rest random.
        for (int a = 0; a < DEPTH; a++)
            cyc(1'b0, 0, 1'b1, a, (a < 16) ? DW'(a) : rand_word());
        idle(2);

        for (int a = 0; a < 16; a++) cyc(1'b1, a, 1'b0, 0, '0);
        idle(MEM_DELAY + 2);

        cyc(1'b0, 0, 1'b1, 3, {(DW/8){8'hA5}});
        cyc(1'b1, 3, 1'b0, 0, '0);
        idle(MEM_DELAY + 2);

        cyc(1'b1, 10, 1'b1, 10, DW'(8'h77));
        cyc(1'b1, 11, 1'b0, 0, '0);
        cyc(1'b0, 0, 1'b1, 11, DW'(8'h55));
        idle(MEM_DELAY + 2);

        cyc(1'b1, DEPTH, 1'b0, 0, '0);
        idle(2);
        cyc(1'b0, 0, 1'b0, 0, '0, 1'b1);
        idle(MEM_DELAY);
        cyc(1'b0, 0, 1'b1, 16'hFFFF, rand_word(), 1'b1);
        idle(2);
        cyc(1'b0, 0, 1'b0, 0, '0, 1'b1);
        idle(1);

        for (int a = 20; a < 24; a++) cyc(1'b1, a, 1'b0, 0, '0);
        idle(2);
        cyc(1'b0, 0, 1'b1, 20, rand_word(), 1'b0, 1'b1);
        idle(10);
        for (int a = 20; a < 24; a++) cyc(1'b1, a, 1'b0, 0, '0);
        idle(MEM_DELAY + 2);

        for (int i = 0; i < 5; i++) cyc(1'b1, 100 + i, 1'b0, 0, '0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b1, 200 + i, rand_word());
        cyc(1'b0, 0, 1'b1, DEPTH + 5, rand_word());
        idle(MEM_DELAY + 1);
        cyc(1'b0, 0, 1'b0, 0, '0, 1'b1);
        idle(2);

        for (int i = 0; i < 1500; i++) begin
            int ra;
            int wa;
            ra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, DEPTH - 1));
            wa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 31) == 0) ra = int'($urandom_range(DEPTH, 65535));
            if ($urandom_range(0, 31) == 0) wa = int'($urandom_range(DEPTH, 65535));
            cyc(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa, rand_word(),
                ($urandom_range(0, 63) == 0), ($urandom_range(0, 255) == 0));
        end
        idle(MEM_DELAY + 4);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule : tb_reshaper_mem_rsp
`default_nettype wire
